monitoring_scheduler: RTL and testbench

- Sits between uart_rx and conexao_sensor, and between conexao_sensor and uart_tx.
- Sequences one sensor transaction at a time and forwards each response to the transmitter.
- In continuous-monitoring mode, re-issues the last read command every PERIOD_CYCLES until a stop command, a cancel_monitoring edge or reset ends it.
- Enforces a response timeout so a dead sensor cannot hang the link.

---
 rtl/monitoring_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_monitoring_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitoring_scheduler.sv
// rtl/monitoring_scheduler.sv - one-at-a-time sensor sequencer with continuous re-issue and response timeout
// Optional build macro MONITOR_SKIP_DUPLICATE_EN: suppress repeated identical readings within a session.
module monitoring_scheduler #(
    parameter int          PERIOD_CYCLES  = 100000000,
    parameter int          TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  CMD_CONT_TEMP  = 8'h05,
    parameter logic [7:0]  CMD_CONT_HUM   = 8'h06,
    parameter logic [7:0]  CMD_STOP       = 8'h07,
    parameter logic [7:0]  RSP_STOP_ACK   = 8'h0A,
    parameter logic [7:0]  RSP_TIMEOUT    = 8'h1F
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_command,
    input  logic [7:0] rx_address,
    input  logic       cancel_monitoring,
    output logic       sensor_start,
    output logic [7:0] sensor_command,
    output logic [7:0] sensor_address,
    input  logic       sensor_done,
    input  logic [7:0] sensor_rsp_command,
    input  logic [7:0] sensor_rsp_value,
    output logic       tx_start,
    output logic [7:0] tx_command,
    output logic [7:0] tx_value,
    input  logic       tx_done,
    output logic       monitoring_active,
    output logic       busy
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = '1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SENSOR,
        S_SEND,
        S_WAIT_TX,
        S_HOLD
    } state_t;

    state_t           state_q;
    logic             pend_valid_q;
    logic [7:0]       pend_cmd_q;
    logic [7:0]       pend_addr_q;
    logic             cont_q;
    logic [7:0]       sess_cmd_q;
    logic [7:0]       sess_addr_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [PER_W-1:0] per_cnt_q;
    logic             cancel_meta_q;
    logic             cancel_sync_q;
    logic             cancel_prev_q;
    logic             sensor_start_q;
    logic [7:0]       sensor_command_q;
    logic [7:0]       sensor_address_q;
    logic             tx_start_q;
    logic [7:0]       tx_command_q;
    logic [7:0]       tx_value_q;
`ifdef MONITOR_SKIP_DUPLICATE_EN
    logic             have_sent_q;
    logic [7:0]       last_value_q;
`endif

    logic cancel_rise;
    logic stop_now;
    logic end_cont;
    logic pend_consume;
    logic is_cont_cmd;

    assign cancel_rise  = cancel_sync_q & ~cancel_prev_q;
    assign stop_now     = rx_valid && (rx_command == CMD_STOP);
    assign end_cont     = cancel_rise | stop_now;
    assign pend_consume = (state_q == S_IDLE) && pend_valid_q;
    assign is_cont_cmd  = (pend_cmd_q == CMD_CONT_TEMP) || (pend_cmd_q == CMD_CONT_HUM);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cancel_meta_q <= 1'b0;
            cancel_sync_q <= 1'b0;
            cancel_prev_q <= 1'b0;
        end else begin
            cancel_meta_q <= cancel_monitoring;
            cancel_sync_q <= cancel_meta_q;
            cancel_prev_q <= cancel_sync_q;
        end
    end

    // A fresh request always wins over clearing, so nothing arriving during consumption is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_cmd_q   <= 8'h00;
            pend_addr_q  <= 8'h00;
        end else if (rx_valid) begin
            pend_valid_q <= 1'b1;
            pend_cmd_q   <= rx_command;
            pend_addr_q  <= rx_address;
        end else if (pend_consume) begin
            pend_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            cont_q           <= 1'b0;
            sess_cmd_q       <= 8'h00;
            sess_addr_q      <= 8'h00;
            to_cnt_q         <= '0;
            per_cnt_q        <= '0;
            sensor_start_q   <= 1'b0;
            sensor_command_q <= 8'h00;
            sensor_address_q <= 8'h00;
            tx_start_q       <= 1'b0;
            tx_command_q     <= 8'h00;
            tx_value_q       <= 8'h00;
`ifdef MONITOR_SKIP_DUPLICATE_EN
            have_sent_q      <= 1'b0;
            last_value_q     <= 8'h00;
`endif
        end else begin
            sensor_start_q <= 1'b0;
            tx_start_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pend_valid_q) begin
                        if (pend_cmd_q == CMD_STOP) begin
                            tx_command_q <= RSP_STOP_ACK;
                            tx_value_q   <= 8'h00;
                            tx_start_q   <= 1'b1;
                            state_q      <= S_SEND;
                        end else begin
                            sensor_command_q <= pend_cmd_q;
                            sensor_address_q <= pend_addr_q;
                            sensor_start_q   <= 1'b1;
                            state_q          <= S_ISSUE;
                            if (is_cont_cmd) begin
                                cont_q      <= 1'b1;
                                sess_cmd_q  <= pend_cmd_q;
                                sess_addr_q <= pend_addr_q;
`ifdef MONITOR_SKIP_DUPLICATE_EN
                                have_sent_q <= 1'b0;
`endif
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT_SENSOR;
                end
                S_WAIT_SENSOR: begin
                    if (sensor_done) begin
`ifdef MONITOR_SKIP_DUPLICATE_EN
                        if (cont_q && !end_cont && have_sent_q && (sensor_rsp_value == last_value_q)) begin
                            per_cnt_q <= '0;
                            state_q   <= S_HOLD;
                        end else begin
                            have_sent_q  <= 1'b1;
                            last_value_q <= sensor_rsp_value;
                            tx_command_q <= sensor_rsp_command;
                            tx_value_q   <= sensor_rsp_value;
                            tx_start_q   <= 1'b1;
                            state_q      <= S_SEND;
                        end
`else
                        tx_command_q <= sensor_rsp_command;
                        tx_value_q   <= sensor_rsp_value;
                        tx_start_q   <= 1'b1;
                        state_q      <= S_SEND;
`endif
                    end else if (to_cnt_q == TO_LAST) begin
                        tx_command_q <= RSP_TIMEOUT;
                        tx_value_q   <= sensor_address_q;
                        tx_start_q   <= 1'b1;
                        cont_q       <= 1'b0;
                        state_q      <= S_SEND;
                    end else if (to_cnt_q != TO_MAX) begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_SEND: begin
                    state_q <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        if (cont_q && !end_cont) begin
                            per_cnt_q <= '0;
                            state_q   <= S_HOLD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    // Any new request ends the session; IDLE restarts it if that request is continuous.
                    if (end_cont || pend_valid_q) begin
                        cont_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (per_cnt_q == PER_LAST) begin
                        sensor_command_q <= sess_cmd_q;
                        sensor_address_q <= sess_addr_q;
                        sensor_start_q   <= 1'b1;
                        state_q          <= S_ISSUE;
                    end else if (per_cnt_q != PER_MAX) begin
                        per_cnt_q <= per_cnt_q + PER_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (end_cont) begin
                cont_q <= 1'b0;
            end
        end
    end

    assign sensor_start      = sensor_start_q;
    assign sensor_command    = sensor_command_q;
    assign sensor_address    = sensor_address_q;
    assign tx_start          = tx_start_q;
    assign tx_command        = tx_command_q;
    assign tx_value          = tx_value_q;
    assign monitoring_active = cont_q;
    assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_monitoring_scheduler.sv
// tb/tb_monitoring_scheduler.sv - scoreboard bench for monitoring_scheduler with randomized transactions
module tb_monitoring_scheduler;

    localparam int PERIOD  = 100;
    localparam int TIMEOUT = 50;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_command = 8'h00;
    logic [7:0] rx_address = 8'h00;
    logic       cancel_monitoring = 1'b0;
    logic       sensor_start;
    logic [7:0] sensor_command;
    logic [7:0] sensor_address;
    logic       sensor_done = 1'b0;
    logic [7:0] sensor_rsp_command = 8'h00;
    logic [7:0] sensor_rsp_value = 8'h00;
    logic       tx_start;
    logic [7:0] tx_command;
    logic [7:0] tx_value;
    logic       tx_done = 1'b0;
    logic       monitoring_active;
    logic       busy;

    monitoring_scheduler #(
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .rx_valid          (rx_valid),
        .rx_command        (rx_command),
        .rx_address        (rx_address),
        .cancel_monitoring (cancel_monitoring),
        .sensor_start      (sensor_start),
        .sensor_command    (sensor_command),
        .sensor_address    (sensor_address),
        .sensor_done       (sensor_done),
        .sensor_rsp_command(sensor_rsp_command),
        .sensor_rsp_value  (sensor_rsp_value),
        .tx_start          (tx_start),
        .tx_command        (tx_command),
        .tx_value          (tx_value),
        .tx_done           (tx_done),
        .monitoring_active (monitoring_active),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    // kind: 0 = no timing check, 1 = latency from stimulus, 2 = period / timeout distance
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         kind;
    } exp_t;

    typedef struct {
        bit         noreply;
        int         delay;
        logic [7:0] c;
        logic [7:0] v;
    } plan_t;

    exp_t  exp_issue[$];
    exp_t  exp_tx[$];
    plan_t plan_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rx_cyc = 0;
    int done_cyc = 0;
    int txdone_cyc = 0;
    int last_start_cyc = 0;
    int tx_done_count = 0;
    int tx_start_count = 0;
    bit tx_hold = 1'b0;
    exp_t mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic bound_ok(input string nm, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=expired required=event", nm);
        end
    endtask

    always @(negedge clock) begin
        if (sensor_start) begin
            if (exp_issue.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sensor_start actual=%h_%h required=none", sensor_command, sensor_address);
            end else begin
                mon_e = exp_issue.pop_front();
                check("issue_cmd", 32'(sensor_command), 32'(mon_e.a));
                check("issue_addr", 32'(sensor_address), 32'(mon_e.b));
                if (mon_e.kind == 1) check("issue_latency", 32'(cyc - rx_cyc), 32'd2);
                if (mon_e.kind == 2) check("reissue_period", 32'(cyc - txdone_cyc), 32'(PERIOD + 1));
            end
            last_start_cyc = cyc;
        end
        if (tx_start) begin
            tx_start_count++;
            if (exp_tx.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tx_start actual=%h_%h required=none", tx_command, tx_value);
            end else begin
                mon_e = exp_tx.pop_front();
                check("tx_cmd", 32'(tx_command), 32'(mon_e.a));
                check("tx_value", 32'(tx_value), 32'(mon_e.b));
                if (mon_e.kind == 1) check("tx_latency", 32'(cyc - done_cyc), 32'd1);
                if (mon_e.kind == 2) check("timeout_latency", 32'(cyc - last_start_cyc), 32'(TIMEOUT + 1));
            end
        end
    end

    initial begin
        plan_t p;
        forever begin
            @(negedge clock);
            if (sensor_start && plan_q.size() != 0) begin
                p = plan_q.pop_front();
                if (!p.noreply) begin
                    repeat (p.delay) @(negedge clock);
                    sensor_done = 1'b1;
                    sensor_rsp_command = p.c;
                    sensor_rsp_value = p.v;
                    done_cyc = cyc;
                    @(negedge clock);
                    sensor_done = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (tx_start && !tx_hold) begin
                repeat ($urandom_range(1, 4)) @(negedge clock);
                tx_done = 1'b1;
                txdone_cyc = cyc;
                tx_done_count++;
                @(negedge clock);
                tx_done = 1'b0;
            end
        end
    end

    function automatic logic [7:0] rand_cmd();
        logic [7:0] c;
        do c = 8'($urandom); while (c == 8'h05 || c == 8'h06 || c == 8'h07);
        return c;
    endfunction

    // mode: 0 = random reply or silence, 1 = always reply, 2 = never reply
    task automatic plan_read(input logic [7:0] cmd, input logic [7:0] addr, input int ikind,
                             input int mode, input int dly);
        exp_t  e;
        plan_t p;
        e.a = cmd;
        e.b = addr;
        e.kind = ikind;
        exp_issue.push_back(e);
        p.noreply = (mode == 2) || (mode == 0 && $urandom_range(0, 3) == 0);
        p.delay = (dly > 0) ? dly : $urandom_range(1, 40);
        p.c = 8'($urandom);
        p.v = 8'($urandom);
        plan_q.push_back(p);
        if (p.noreply) begin
            e.a = 8'h1F;
            e.b = addr;
            e.kind = 2;
        end else begin
            e.a = p.c;
            e.b = p.v;
            e.kind = 1;
        end
        exp_tx.push_back(e);
    endtask

    task automatic send_req(input logic [7:0] cmd, input logic [7:0] addr);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_command = cmd;
        rx_address = addr;
        rx_cyc = cyc;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        repeat (4) @(negedge clock);
        while ((busy || exp_issue.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        bound_ok(nm, n < 3000);
    endtask

    task automatic wait_txdone(input string nm, input int target);
        int n = 0;
        while (tx_done_count < target && n < 2000) begin
            @(negedge clock);
            n++;
        end
        bound_ok(nm, n < 2000);
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] a;
        int base;
        int n;

        #12;
        check("rst_sensor_start", 32'(sensor_start), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_outputs", {sensor_command, sensor_address, tx_command, tx_value},
              32'd0);
        check("rst_active", 32'(monitoring_active), 32'd0);

        plan_read(8'h01, 8'h01, 1, 1, 10);
        send_req(8'h01, 8'h01);
        wait_idle("single_read_done");
        check("single_active", 32'(monitoring_active), 32'd0);

        plan_read(8'h02, 8'h03, 1, 2, 0);
        send_req(8'h02, 8'h03);
        wait_idle("timeout_done");

        for (int i = 0; i < 10; i++) begin
            c = rand_cmd();
            a = 8'($urandom);
            plan_read(c, a, 1, 0, 0);
            send_req(c, a);
            wait_idle("random_read_done");
        end

        for (int s = 0; s < 2; s++) begin
            c = (s == 0) ? 8'h05 : 8'h06;
            a = 8'($urandom);
            n = $urandom_range(2, 3);
            base = tx_done_count;
            plan_read(c, a, 1, 1, 0);
            for (int i = 1; i < n; i++) plan_read(c, a, 2, 1, 0);
            send_req(c, a);
            wait_txdone("cont_reads", base + n);
            repeat (3) @(negedge clock);
            check("cont_active", 32'(monitoring_active), 32'd1);
            check("cont_hold_busy", 32'(busy), 32'd1);
            repeat ($urandom_range(5, 50)) @(negedge clock);
            mon_e.a = 8'h0A;
            mon_e.b = 8'h00;
            mon_e.kind = 0;
            exp_tx.push_back(mon_e);
            send_req(8'h07, 8'h01);
            check("stop_active", 32'(monitoring_active), 32'd0);
            wait_idle("stop_ack_done");
            repeat (PERIOD + 20) @(negedge clock);
            check("stop_no_reissue", 32'(busy), 32'd0);
        end

        a = 8'($urandom);
        base = tx_done_count;
        plan_read(8'h05, a, 1, 1, 0);
        send_req(8'h05, a);
        wait_txdone("cancel_first_read", base + 1);
        repeat (5) @(negedge clock);
        cancel_monitoring = 1'b1;
        repeat (3) @(negedge clock);
        check("cancel_active", 32'(monitoring_active), 32'd0);
        repeat (2) @(negedge clock);
        cancel_monitoring = 1'b0;
        repeat (2 * PERIOD) @(negedge clock);
        check("cancel_idle", 32'(busy), 32'd0);

        c = rand_cmd();
        plan_read(8'h11, 8'h22, 1, 1, 30);
        plan_read(c, 8'h44, 0, 1, 0);
        send_req(8'h11, 8'h22);
        repeat (5) @(negedge clock);
        send_req(8'h01, 8'h33);
        repeat (3) @(negedge clock);
        send_req(c, 8'h44);
        wait_idle("overwrite_done");

        tx_hold = 1'b1;
        base = tx_start_count;
        plan_read(8'h03, 8'h09, 1, 1, 0);
        send_req(8'h03, 8'h09);
        n = 0;
        while (tx_start_count == base && n < 200) begin
            @(negedge clock);
            n++;
        end
        bound_ok("reset_wait_tx", n < 200);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_strobes", {30'd0, sensor_start, tx_start}, 32'd0);
        check("rst_mid_data", {sensor_command, sensor_address, tx_command, tx_value}, 32'd0);
        check("rst_mid_active", 32'(monitoring_active), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        tx_hold = 1'b0;
        base = tx_start_count;
        repeat (60) @(negedge clock);
        check("rst_no_tx", 32'(tx_start_count), 32'(base));
        check("rst_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(10 * 90000);
        bad++;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
